// File: rtl/card_pkg.sv
// Shared card-rank and seven-segment definitions for the card-game datapath.
package card_pkg;

  typedef logic [3:0] rank_t;
  typedef logic [6:0] seg7_t;

  // Ranks with a letter glyph; 2..9 are their own numeric code.
  localparam rank_t RANK_ACE   = 4'd1;
  localparam rank_t RANK_TEN   = 4'd10;
  localparam rank_t RANK_JACK  = 4'd11;
  localparam rank_t RANK_QUEEN = 4'd12;
  localparam rank_t RANK_KING  = 4'd13;

  // Active-low patterns, bit order [6:0] = g f e d c b a.
  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_A     = 7'b0001000;
  localparam seg7_t SEG_2     = 7'b0100100;
  localparam seg7_t SEG_3     = 7'b0110000;
  localparam seg7_t SEG_4     = 7'b0011001;
  localparam seg7_t SEG_5     = 7'b0010010;
  localparam seg7_t SEG_6     = 7'b0000010;
  localparam seg7_t SEG_7     = 7'b1111000;
  localparam seg7_t SEG_8     = 7'b0000000;
  localparam seg7_t SEG_9     = 7'b0010000;
  localparam seg7_t SEG_0     = 7'b1000000;
  localparam seg7_t SEG_J     = 7'b1100001;
  localparam seg7_t SEG_Q     = 7'b0011000;
  localparam seg7_t SEG_K     = 7'b0001001;

endpackage

// File: rtl/card_seg_decode.sv
// Combinational rank-to-segment decoder, shared by every HEX digit in the game top.
module card_seg_decode
  import card_pkg::*;
(
  input  rank_t rank,
  output seg7_t seg
);

  // Map each valid rank to its glyph; anything else (0, 14, 15, unknown) is blank.
  always_comb begin
    seg = SEG_BLANK;
    case (rank)
      RANK_ACE:   seg = SEG_A;
      4'd2:       seg = SEG_2;
      4'd3:       seg = SEG_3;
      4'd4:       seg = SEG_4;
      4'd5:       seg = SEG_5;
      4'd6:       seg = SEG_6;
      4'd7:       seg = SEG_7;
      4'd8:       seg = SEG_8;
      4'd9:       seg = SEG_9;
      RANK_TEN:   seg = SEG_0;
      RANK_JACK:  seg = SEG_J;
      RANK_QUEEN: seg = SEG_Q;
      RANK_KING:  seg = SEG_K;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/card_7seg.sv
// Registered card-rank display: decode SW and hold the pattern in an async-reset register.
module card_7seg
  import card_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] SW,
  output logic [6:0] HEX0
);

  seg7_t seg_next;

  card_seg_decode u_decode (
    .rank (SW),
    .seg  (seg_next)
  );

  // Output register: reset blanks the digit immediately, otherwise load the decode each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HEX0 <= SEG_BLANK;
    end else begin
      HEX0 <= seg_next;
    end
  end

endmodule

// File: tb/tb_card_7seg.sv
// Bench for card_7seg: directed vectors, reset/latency sequences and randomized traffic.
module tb_card_7seg;

  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] SW = 4'd0;
  logic [6:0] HEX0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] exp_q[$];

  typedef struct {
    logic [3:0] sw;
    logic [6:0] exp;
  } vec_t;

  vec_t       vecs[16];
  logic [6:0] glyph_tab[16];

  card_7seg dut (
    .clk  (clk),
    .reset(reset),
    .SW   (SW),
    .HEX0 (HEX0)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference: a rank is shown only if it is a real card (1..13) and reset is low.
  function automatic logic [6:0] ref_model(input logic [3:0] sw, input logic rst);
    if (rst || $isunknown(sw)) return BLANK;
    if (sw < 4'd1 || sw > 4'd13) return BLANK;
    return glyph_tab[sw];
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: HEX0=%b expected %b", name, act, exp);
    end
  endtask

  // Drive SW at the falling edge, then settle just after the next rising edge.
  task automatic step(input logic [3:0] sw);
    @(negedge clk);
    SW = sw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Glyph table for the card ranks, written from the display chart.
    foreach (glyph_tab[i]) glyph_tab[i] = BLANK;
    glyph_tab[1]  = 7'b0001000;
    glyph_tab[2]  = 7'b0100100;
    glyph_tab[3]  = 7'b0110000;
    glyph_tab[4]  = 7'b0011001;
    glyph_tab[5]  = 7'b0010010;
    glyph_tab[6]  = 7'b0000010;
    glyph_tab[7]  = 7'b1111000;
    glyph_tab[8]  = 7'b0000000;
    glyph_tab[9]  = 7'b0010000;
    glyph_tab[10] = 7'b1000000;
    glyph_tab[11] = 7'b1100001;
    glyph_tab[12] = 7'b0011000;
    glyph_tab[13] = 7'b0001001;

    // Sweep 1..15 then 0, with literal expectations.
    vecs[0]  = '{4'd1,  7'b0001000};
    vecs[1]  = '{4'd2,  7'b0100100};
    vecs[2]  = '{4'd3,  7'b0110000};
    vecs[3]  = '{4'd4,  7'b0011001};
    vecs[4]  = '{4'd5,  7'b0010010};
    vecs[5]  = '{4'd6,  7'b0000010};
    vecs[6]  = '{4'd7,  7'b1111000};
    vecs[7]  = '{4'd8,  7'b0000000};
    vecs[8]  = '{4'd9,  7'b0010000};
    vecs[9]  = '{4'd10, 7'b1000000};
    vecs[10] = '{4'd11, 7'b1100001};
    vecs[11] = '{4'd12, 7'b0011000};
    vecs[12] = '{4'd13, 7'b0001001};
    vecs[13] = '{4'd14, 7'b1111111};
    vecs[14] = '{4'd15, 7'b1111111};
    vecs[15] = '{4'd0,  7'b1111111};

    // Initial async reset, before any clock edge.
    #1 reset = 1'b1;
    #1 check("reset_initial", HEX0, BLANK);

    // Load an 8 so the display is fully lit.
    @(negedge clk);
    reset = 1'b0;
    SW = 4'd8;
    @(posedge clk);
    #1 check("load_8", HEX0, 7'b0000000);

    // Mid-cycle reset assertion blanks without a clock.
    @(negedge clk);
    reset = 1'b1;
    #1 check("reset_async", HEX0, BLANK);
    for (int i = 0; i < 3; i++) begin
      SW = 4'($urandom_range(1, 13));
      @(posedge clk);
      #1 check("reset_hold", HEX0, BLANK);
    end

    // Reset release with SW=5: stay blank until the first edge.
    @(negedge clk);
    SW = 4'd5;
    #1 reset = 1'b0;
    #1 check("release_pre_edge", HEX0, BLANK);
    @(posedge clk);
    #1 check("release_first_edge", HEX0, 7'b0010010);

    // Full sweep from the table.
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].sw);
      check($sformatf("sweep_sw%0d", vecs[i].sw), HEX0, vecs[i].exp);
    end

    // Latency: a mid-cycle change is not visible until the next edge.
    step(4'd3);
    check("latency_load3", HEX0, 7'b0110000);
    #2 SW = 4'd7;
    #1 check("latency_hold3", HEX0, 7'b0110000);
    @(posedge clk);
    #1 check("latency_load7", HEX0, 7'b1111000);

    // Unknown input decodes to blank with no X on the output.
    @(negedge clk);
    SW = 4'bxxxx;
    @(posedge clk);
    #1 check("unknown_sw", HEX0, BLANK);
    n_tests++;
    if ($isunknown(HEX0)) begin
      n_fail++;
      $display("FAIL unknown_no_x: HEX0=%b expected no X bits", HEX0);
    end

    // Randomized traffic with occasional reset, scored against the reference.
    for (int i = 0; i < 300; i++) begin
      logic r;
      @(negedge clk);
      SW = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 9) == 0);
      reset = r;
      exp_q.push_back(ref_model(SW, r));
      @(posedge clk);
      #1 check($sformatf("random_%0d_sw%0d", i, SW), HEX0, exp_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
